id_scoreboard: RTL



---
 rtl/cpu_pkg.sv | 17 +
 rtl/sb_match.sv | 42 ++++
 rtl/id_scoreboard.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the decode-stage hazard/forwarding scoreboard.
package cpu_pkg;

  localparam int REG_AW_DEF = 4;

  // Forward-select encodings: k+1 selects the result held by shadow stage k.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic                  v;
    logic [REG_AW_DEF-1:0] dest;
    logic                  load;
  } sh_entry_t;

endpackage

// File: rtl/sb_match.sv
// Compares one source register against the shadow stages that can still hazard
// or forward (all but WB); reports the match vector, nearest hit and load-use hit.
module sb_match #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int SW     = 2
) (
  input  logic                        used,
  input  logic [REG_AW-1:0]           src,
  input  logic [DEPTH-2:0]            sh_v,
  input  logic [(DEPTH-1)*REG_AW-1:0] sh_dest,
  input  logic                        load0,
  output logic [DEPTH-2:0]            match,
  output logic                        near_hit,
  output logic [SW-1:0]               near_idx,
  output logic                        load_hit
);

  localparam int NS = DEPTH - 1;

  always_comb begin
    match = '0;
    for (int k = 0; k < NS; k++) begin
      match[k] = used & sh_v[k] & (sh_dest[k*REG_AW +: REG_AW] == src);
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites older hits.
  always_comb begin
    near_hit = 1'b0;
    near_idx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (match[k]) begin
        near_hit = 1'b1;
        near_idx = SW'(k);
      end
    end
  end

  assign load_hit = match[0] & load0;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: shadow pipeline of in-flight destinations producing
// the ID stall, registered EXE forward selects, a pending mask and a stall counter.
module id_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int NREG  = 2**REG_AW,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic              src1_en,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic [REG_AW-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              flush,
  output logic              hazard,
  output logic [SW-1:0]     fwd_sel1,
  output logic [SW-1:0]     fwd_sel2,
  output logic [NREG-1:0]   pending_mask,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0]  sh_v;
  logic [REG_AW-1:0] sh_dest [DEPTH];
  // The load flag only matters while the producer sits in EXE, so only stage 0 keeps it.
  logic              sh0_load;

  logic [(DEPTH-1)*REG_AW-1:0] near_dest;
  logic [DEPTH-2:0]            m1, m2;
  logic                        hit1, hit2, lh1, lh2;
  logic [SW-1:0]               idx1, idx2;
  logic                        insert;

  always_comb begin
    near_dest = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      near_dest[k*REG_AW +: REG_AW] = sh_dest[k];
    end
  end

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(SW)) u_match1 (
    .used     (id_valid & src1_en),
    .src      (src1),
    .sh_v     (sh_v[DEPTH-2:0]),
    .sh_dest  (near_dest),
    .load0    (sh0_load),
    .match    (m1),
    .near_hit (hit1),
    .near_idx (idx1),
    .load_hit (lh1)
  );

  sb_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .SW(SW)) u_match2 (
    .used     (id_valid & two_src),
    .src      (src2),
    .sh_v     (sh_v[DEPTH-2:0]),
    .sh_dest  (near_dest),
    .load0    (sh0_load),
    .match    (m2),
    .near_hit (hit2),
    .near_idx (idx2),
    .load_hit (lh2)
  );

  assign hazard = ~flush & ((FWD_EN != 0) ? (lh1 | lh2) : (|(m1 | m2)));
  assign insert = id_valid & ~hazard & ~flush;

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sh_v[k]) pending_mask[sh_dest[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_v      <= '0;
      sh0_load  <= 1'b0;
      fwd_sel1  <= '0;
      fwd_sel2  <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) sh_dest[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sh_v[k]    <= sh_v[k-1];
        sh_dest[k] <= sh_dest[k-1];
      end
      sh_v[0]    <= insert & wb_en;
      sh_dest[0] <= dest;
      sh0_load   <= insert & mem_r_en;
      fwd_sel1   <= (insert && FWD_EN != 0 && hit1) ? idx1 + SW'(1) : '0;
      fwd_sel2   <= (insert && FWD_EN != 0 && hit2) ? idx2 + SW'(1) : '0;
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
